convolution_coprocessor_mac_engine: RTL
=======================================

Name: convolution_coprocessor_mac_engine

Overview:
- Sequencer and MAC datapath directly downstream of the coefficient ROM (h[k]) and sample ROM (x[j]). Both ROMs are synchronous-read with 1-cycle latency.
- On start, computes the full linear convolution y[n] = sum_k h[k]*x[n-k] for n = 0..size_h+size_x-2, one output at a time.
- Drives both ROM read addresses and writes each y[n] to a downstream result memory through a single-cycle write strobe.

Parameters:
- DATA_WIDTH, 8, width of h and x samples (unsigned).
- ADDR_WIDTH, 5, ROM address width; max sequence length 2**ADDR_WIDTH.
- ACC_WIDTH, 2*DATA_WIDTH+ADDR_WIDTH (21), accumulator and y width; overflow-free by construction.

Ports:
- clk  in  1  single clock; all state on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- start_i  in  1  start request, sampled in IDLE only.
- size_h_i  in  ADDR_WIDTH+1  number of coefficients, valid 1..2**ADDR_WIDTH; latched at start.
- size_x_i  in  ADDR_WIDTH+1  number of samples, same range; latched at start.
- h_addr_o  out  ADDR_WIDTH  coefficient ROM read address.
- h_data_i  in  DATA_WIDTH  coefficient ROM data; valid 1 cycle after the address.
- x_addr_o  out  ADDR_WIDTH  sample ROM read address.
- x_data_i  in  DATA_WIDTH  sample ROM data; valid 1 cycle after the address.
- y_we_o  out  1  result write strobe, one cycle per output.
- y_addr_o  out  ADDR_WIDTH+1  result index n.
- y_data_o  out  ACC_WIDTH  result value y[n].
- busy_o  out  1  high from the cycle after start is accepted until DONE exits.
- done_o  out  1  single-cycle completion pulse.

Behaviour:
- Reset: all outputs 0; state IDLE; accumulator, n and k cleared. Reset asserted mid-run aborts immediately: no further writes and no done pulse.
- FSM states: IDLE, LOAD, MAC, DRAIN, WRITE, DONE.
- IDLE:
  - start_i=1 with both sizes in range: latch sizes, set n=0, go to LOAD.
  - start_i=1 with either size equal to 0: go straight to DONE with no writes.
  - start_i=1 with a size above 2**ADDR_WIDTH: clamp that size to 2**ADDR_WIDTH.
- LOAD (1 cycle):
  - kmin = max(0, n-(size_x-1)); kmax = min(n, size_h-1).
  - k = kmin; accumulator cleared.
- MAC (kmax-kmin+1 cycles):
  - Each cycle drive h_addr_o=k and x_addr_o=n-k.
  - From the second MAC cycle on, add h_data_i*x_data_i (zero-extended) to the accumulator.
  - k increments each cycle; after issuing k=kmax, go to DRAIN.
- DRAIN (1 cycle): accumulate the final returned product.
- WRITE (1 cycle):
  - y_we_o=1, y_addr_o=n, y_data_o=accumulator.
  - If n = size_h+size_x-2, go to DONE; else n++ and go to LOAD.
- DONE (1 cycle): done_o=1, busy_o=0; then IDLE.
- Output timing: y_we_o, y_addr_o and y_data_o are registered. y_addr_o and y_data_o hold their last values outside WRITE; only y_we_o qualifies them.
- Address hold: ROM addresses hold their last value outside MAC.
- Cycles per output: taps(n)+3. Total from start acceptance edge to done_o = sum over n of (taps(n)+3), plus 1.
- start_i while busy is ignored. start_i high in the same cycle as done_o is ignored; it is accepted in the following IDLE cycle.
- Sizes are latched, so input changes during a run have no effect.

Decomposition:
- Package convolution_coprocessor_pkg holds:
  - the state enum (state_e);
  - constants DATA_WIDTH_C=8, ADDR_WIDTH_C=5, ACC_WIDTH_C=21;
  - a length_t typedef of ADDR_WIDTH+1 bits.
- Sub-module convolution_coprocessor_tap_range: combinational kmin/kmax from n, size_h and size_x, so it can be unit-tested separately.
- The FSM and MAC stay in the top module.

Test Plan:
- size_h=1, size_x=1, h=[3], x=[4] -> one write: y_addr=0, y_data=12; done_o 5 cycles after start accepted.
- h=[1,2,3], x=[1,1,1,1] -> writes y=[1,3,6,6,5,3] at addresses 0..5 in order; done_o 31 cycles after start; each ROM address sequence matches kmin..kmax.
- size_h=size_x=32, all samples 0xFF -> y[31]=2080800 (0x1FC020), no overflow; 63 writes total.
- Pulse start_i during MAC and again on the done_o cycle -> no restart and no extra writes; busy_o stays high throughout the run.
- size_h=0, start -> done_o next cycle, y_we_o never asserted.
- Assert rst mid-MAC of a 3x4 run -> all outputs 0 immediately, FSM in IDLE, no done_o. A fresh start then produces the full correct result.

Source files
------------

// File: rtl/convolution_coprocessor_mac_engine_pkg.sv
// Shared types and constants for the convolution MAC engine: widths, state
// encoding and the sequence-length type used for sizes and output indices.
package convolution_coprocessor_pkg;
  localparam int DATA_WIDTH_C = 8;
  localparam int ADDR_WIDTH_C = 5;
  localparam int ACC_WIDTH_C  = 2*DATA_WIDTH_C + ADDR_WIDTH_C;

  // One bit wider than a ROM address so that 2**ADDR_WIDTH itself fits.
  typedef logic [ADDR_WIDTH_C:0] length_t;

  localparam length_t MAX_LEN_C = length_t'(2**ADDR_WIDTH_C);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_MAC,
    ST_DRAIN,
    ST_WRITE,
    ST_DONE
  } state_e;

  function automatic length_t clamp_len(input length_t len);
    return (len > MAX_LEN_C) ? MAX_LEN_C : len;
  endfunction
endpackage

// File: rtl/convolution_coprocessor_mac_engine_if.sv
// Control, ROM-read and result-write signals between the MAC engine and its
// surroundings; suffixes are from the engine's point of view.
interface convolution_coprocessor_mac_engine_if;
  import convolution_coprocessor_pkg::*;

  logic                    start_i;
  length_t                 size_h_i;
  length_t                 size_x_i;
  logic [ADDR_WIDTH_C-1:0] h_addr_o;
  logic [DATA_WIDTH_C-1:0] h_data_i;
  logic [ADDR_WIDTH_C-1:0] x_addr_o;
  logic [DATA_WIDTH_C-1:0] x_data_i;
  logic                    y_we_o;
  length_t                 y_addr_o;
  logic [ACC_WIDTH_C-1:0]  y_data_o;
  logic                    busy_o;
  logic                    done_o;

  modport slave (
    input  start_i, size_h_i, size_x_i, h_data_i, x_data_i,
    output h_addr_o, x_addr_o, y_we_o, y_addr_o, y_data_o, busy_o, done_o
  );

  modport master (
    output start_i, size_h_i, size_x_i, h_data_i, x_data_i,
    input  h_addr_o, x_addr_o, y_we_o, y_addr_o, y_data_o, busy_o, done_o
  );
endinterface

// File: rtl/convolution_coprocessor_tap_range.sv
// Valid tap window for output index n: k runs kmin..kmax so that both
// h[k] and x[n-k] stay inside their sequences.
module convolution_coprocessor_tap_range
  import convolution_coprocessor_pkg::*;
(
  input  length_t n_i,
  input  length_t size_h_i,
  input  length_t size_x_i,
  output length_t kmin_o,
  output length_t kmax_o
);
  length_t h_last, x_last;

  assign h_last = size_h_i - length_t'(1);
  assign x_last = size_x_i - length_t'(1);
  assign kmin_o = (n_i > x_last) ? (n_i - x_last) : '0;
  assign kmax_o = (n_i < h_last) ? n_i : h_last;
endmodule

// File: rtl/convolution_coprocessor_mac_engine.sv
// Convolution sequencer + MAC: walks n over all outputs, streams h[k]*x[n-k]
// from two 1-cycle ROMs into an accumulator and writes each y[n] out.
module convolution_coprocessor_mac_engine
  import convolution_coprocessor_pkg::*;
(
  input  logic                                clk,
  input  logic                                rst,
  convolution_coprocessor_mac_engine_if.slave bus
);
  state_e                  state_q;
  length_t                 size_h_q, size_x_q, last_n_q, n_q, k_q, kmax_q;
  logic                    first_q;
  logic [ACC_WIDTH_C-1:0]  acc_q;
  logic [ADDR_WIDTH_C-1:0] h_addr_q, x_addr_q;
  logic                    y_we_q, busy_q, done_q;
  length_t                 y_addr_q;
  logic [ACC_WIDTH_C-1:0]  y_data_q;

  length_t                 sh_in, sx_in, last_n_d, kmin, kmax, k_nxt;
  logic [ADDR_WIDTH_C-1:0] x_first, x_nxt;
  logic [ACC_WIDTH_C-1:0]  prod, acc_d;

  convolution_coprocessor_tap_range u_tap_range (
    .n_i      (n_q),
    .size_h_i (size_h_q),
    .size_x_i (size_x_q),
    .kmin_o   (kmin),
    .kmax_o   (kmax)
  );

  assign sh_in = clamp_len(bus.size_h_i);
  assign sx_in = clamp_len(bus.size_x_i);
  // Wraps mod 2**(ADDR_WIDTH+1) in the middle, but the true result (<= 62) fits.
  assign last_n_d = sh_in + sx_in - length_t'(2);

  assign k_nxt   = k_q + length_t'(1);
  assign x_first = n_q[ADDR_WIDTH_C-1:0] - kmin[ADDR_WIDTH_C-1:0];
  assign x_nxt   = n_q[ADDR_WIDTH_C-1:0] - k_nxt[ADDR_WIDTH_C-1:0];

  assign prod  = {{(ACC_WIDTH_C-DATA_WIDTH_C){1'b0}}, bus.h_data_i}
               * {{(ACC_WIDTH_C-DATA_WIDTH_C){1'b0}}, bus.x_data_i};
  assign acc_d = acc_q + prod;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      size_h_q <= '0;
      size_x_q <= '0;
      last_n_q <= '0;
      n_q      <= '0;
      k_q      <= '0;
      kmax_q   <= '0;
      first_q  <= 1'b0;
      acc_q    <= '0;
      h_addr_q <= '0;
      x_addr_q <= '0;
      y_we_q   <= 1'b0;
      y_addr_q <= '0;
      y_data_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      y_we_q <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.start_i) begin
            if (bus.size_h_i == '0 || bus.size_x_i == '0) begin
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end else begin
              size_h_q <= sh_in;
              size_x_q <= sx_in;
              last_n_q <= last_n_d;
              n_q      <= '0;
              busy_q   <= 1'b1;
              state_q  <= ST_LOAD;
            end
          end
        end
        ST_LOAD: begin
          k_q      <= kmin;
          kmax_q   <= kmax;
          acc_q    <= '0;
          first_q  <= 1'b1;
          h_addr_q <= kmin[ADDR_WIDTH_C-1:0];
          x_addr_q <= x_first;
          state_q  <= ST_MAC;
        end
        ST_MAC: begin
          // ROM data in the first MAC cycle belongs to stale addresses.
          first_q <= 1'b0;
          if (!first_q) acc_q <= acc_d;
          if (k_q == kmax_q) begin
            state_q <= ST_DRAIN;
          end else begin
            k_q      <= k_nxt;
            h_addr_q <= k_nxt[ADDR_WIDTH_C-1:0];
            x_addr_q <= x_nxt;
          end
        end
        ST_DRAIN: begin
          acc_q    <= acc_d;
          y_we_q   <= 1'b1;
          y_addr_q <= n_q;
          y_data_q <= acc_d;
          state_q  <= ST_WRITE;
        end
        ST_WRITE: begin
          if (n_q == last_n_q) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            n_q     <= n_q + length_t'(1);
            state_q <= ST_LOAD;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.h_addr_o = h_addr_q;
  assign bus.x_addr_o = x_addr_q;
  assign bus.y_we_o   = y_we_q;
  assign bus.y_addr_o = y_addr_q;
  assign bus.y_data_o = y_data_q;
  assign bus.busy_o   = busy_q;
  assign bus.done_o   = done_q;
endmodule
